// File: rtl/apb_gpio.sv
// apb_gpio: command-driven APB3 master plus an 8-bit GPIO slave on the same bus.
// Each write sends the last read value plus one.
module apb_gpio (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic [1:0] ctrl_i,
  input  logic [3:0] paddr_i,
  input  logic [7:0] gpio_i,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [3:0] paddr_o,
  output logic [7:0] pwdata_o,
  output logic [7:0] rdata_o,
  output logic [7:0] gpio_o,
  output logic [7:0] gpio_oe
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t     state_q, state_d;
  logic       pwrite_q, pwrite_d;
  logic [3:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d, rdata_q, rdata_d, out_q, out_d, oe_q, oe_d;
  logic       psel, penable, pready, start, done;
  logic [7:0] prdata;
  assign psel    = state_q != IDLE;
  assign penable = state_q == ACCESS;
  assign pready  = psel & penable;
  assign start   = state_q == IDLE && ctrl_i[0];
  assign done    = state_q == ACCESS && pready;
  // Slave read mux; unmapped addresses and non-read cycles return zero.
  assign prdata = !(psel && !pwrite_q) ? 8'h00 :
                  paddr_q == 4'h0 ? out_q :
                  paddr_q == 4'h1 ? oe_q :
                  paddr_q == 4'h2 ? gpio_i : 8'h00;
  always_comb begin
    state_d  = start ? SETUP : state_q == SETUP ? ACCESS : done ? IDLE : state_q;
    paddr_d  = start ? paddr_i : paddr_q;
    pwrite_d = start ? ctrl_i[1] : pwrite_q;
    pwdata_d = (start && ctrl_i[1]) ? rdata_q + 8'd1 : pwdata_q;
    rdata_d  = (done && !pwrite_q) ? prdata : rdata_q;
    out_d    = (done && pwrite_q && paddr_q == 4'h0) ? pwdata_q : out_q;
    oe_d     = (done && pwrite_q && paddr_q == 4'h1) ? pwdata_q : oe_q;
  end
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= 4'h0;
      pwdata_q <= 8'h00;
      rdata_q  <= 8'h00;
      out_q    <= 8'h00;
      oe_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
    end
  end
  assign psel_o    = psel;
  assign penable_o = penable;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign rdata_o   = rdata_q;
  assign gpio_o    = out_q;
  assign gpio_oe   = oe_q;
endmodule

// File: tb/tb_apb_gpio.sv
// tb_apb_gpio: randomized transfers checked against a register-map model of the GPIO block.
module tb_apb_gpio;
  logic       pclk = 1'b0;
  logic       preset_n;
  logic [1:0] ctrl_i;
  logic [3:0] paddr_i;
  logic [7:0] gpio_i;
  logic       psel_o, penable_o, pwrite_o;
  logic [3:0] paddr_o;
  logic [7:0] pwdata_o, rdata_o, gpio_o, gpio_oe;
  int errors = 0;
  int checks = 0;
  logic [7:0] m_out, m_oe, m_rd, m_pw;

  apb_gpio dut (
    .pclk(pclk), .preset_n(preset_n), .ctrl_i(ctrl_i), .paddr_i(paddr_i), .gpio_i(gpio_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .rdata_o(rdata_o), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_outputs(input string name);
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0 || rdata_o !== m_rd || gpio_o !== m_out ||
        gpio_oe !== m_oe || pwdata_o !== m_pw) begin
      errors++;
      $display("FAIL %s: psel=%b penable=%b rdata=%h gpio_o=%h gpio_oe=%h pwdata=%h, expected 0 0 %h %h %h %h",
               name, psel_o, penable_o, rdata_o, gpio_o, gpio_oe, pwdata_o, m_rd, m_out, m_oe, m_pw);
    end
  endtask

  // One command pulse, entered and left at #1 after an edge with the FSM idle.
  task automatic xfer(input logic wr, input logic [3:0] a, input string name);
    logic [7:0] pw, exp_rd;
    pw = m_rd + 8'd1;
    ctrl_i = wr ? 2'b11 : 2'b01;
    paddr_i = a;
    tick();
    ctrl_i = 2'b00;
    paddr_i = 4'($urandom);
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b0 || pwrite_o !== wr || paddr_o !== a ||
        (wr && pwdata_o !== pw)) begin
      errors++;
      $display("FAIL %s setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, expected 1 0 %b %h %h",
               name, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, wr, a, pw);
    end
    tick();
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1 || pwrite_o !== wr || paddr_o !== a) begin
      errors++;
      $display("FAIL %s access: psel=%b penable=%b pwrite=%b paddr=%h, expected 1 1 %b %h",
               name, psel_o, penable_o, pwrite_o, paddr_o, wr, a);
    end
    exp_rd = a == 4'h0 ? m_out : a == 4'h1 ? m_oe : a == 4'h2 ? gpio_i : 8'h00;
    tick();
    if (wr) begin
      m_pw = pw;
      if (a == 4'h0) m_out = pw;
      if (a == 4'h1) m_oe = pw;
    end else m_rd = exp_rd;
    check_outputs(name);
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    ctrl_i = 2'b00;
    tick();
    tick();
    preset_n = 1'b1;
    m_out = 8'h00; m_oe = 8'h00; m_rd = 8'h00; m_pw = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    check_outputs("reset");
    checks++;
    if (pwrite_o !== 1'b0 || paddr_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: pwrite=%b paddr=%h, expected 0 0", pwrite_o, paddr_o);
    end
    tick();
    check_outputs("reset_idle");
  endtask

  task automatic test_basic();
    gpio_i = 8'hFE;
    xfer(1'b0, 4'h2, "read_in");
    xfer(1'b1, 4'h0, "write_out");
    xfer(1'b1, 4'h1, "write_oe");
    xfer(1'b0, 4'h1, "read_oe");
    xfer(1'b1, 4'h0, "write_out_wrap");
  endtask

  task automatic test_unmapped();
    xfer(1'b1, 4'h2, "write_ro");
    xfer(1'b1, 4'h7, "write_unmapped");
    xfer(1'b0, 4'h7, "read_unmapped");
    ctrl_i = 2'b10;
    tick();
    tick();
    ctrl_i = 2'b00;
    check_outputs("ctrl_10_nop");
  endtask

  task automatic test_reset_mid();
    xfer(1'b0, 4'h1, "pre_reset_read");
    ctrl_i = 2'b11;
    paddr_i = 4'h0;
    tick();
    preset_n = 1'b0;
    ctrl_i = 2'b00;
    tick();
    preset_n = 1'b1;
    m_out = 8'h00; m_oe = 8'h00; m_rd = 8'h00; m_pw = 8'h00;
    check_outputs("reset_mid");
    tick();
    tick();
    check_outputs("reset_mid_idle");
  endtask

  task automatic test_held_ctrl();
    gpio_i = 8'h5A;
    ctrl_i = 2'b01;
    paddr_i = 4'h2;
    tick();
    tick();
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
      errors++;
      $display("FAIL held_access: psel=%b penable=%b, expected 1 1", psel_o, penable_o);
    end
    tick();
    m_rd = 8'h5A;
    check_outputs("held_idle");
    tick();
    ctrl_i = 2'b00;
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b0) begin
      errors++;
      $display("FAIL held_restart: psel=%b penable=%b, expected 1 0", psel_o, penable_o);
    end
    tick();
    tick();
    check_outputs("held_second_done");
  endtask

  task automatic test_back_to_back();
    gpio_i = 8'h3C;
    xfer(1'b0, 4'h2, "b2b_read");
    xfer(1'b1, 4'h1, "b2b_write");
    xfer(1'b0, 4'h1, "b2b_readback");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      gpio_i = 8'($urandom);
      xfer(1'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    preset_n = 1'b0;
    ctrl_i = 2'b00;
    paddr_i = 4'h0;
    gpio_i = 8'h00;
    #1;
    test_reset();
    test_basic();
    test_unmapped();
    test_reset_mid();
    test_held_ctrl();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
